// File: rtl/conv_window_gen_pkg.sv
// rtl/conv_window_gen_pkg.sv - shared widths, defaults and FSM encoding for the window generator
package conv_window_gen_pkg;

    localparam int DWIDTH_DAT   = 12;
    localparam int DWIDTH_SLICE = 3;
    localparam int DWSS         = DWIDTH_SLICE * DWIDTH_SLICE;

    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// rtl/conv_window_gen_line_buffer.sv - one image row of pixel storage, read-old-data on a shared address
module conv_window_gen_line_buffer #(
    parameter int DEPTH = 640,
    parameter int DW    = 12,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= wdata;
        end
    end

    // Asynchronous read sees the pre-edge contents, so a same-cycle write never leaks through.
    assign rdata = mem[addr];

endmodule

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - raster pixel stream to registered NxN convolution windows
module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int N     = DWIDTH_SLICE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sof,
    input  logic                         pix_valid,
    input  logic [DWIDTH_DAT-1:0]        pix_in,
    output logic [DWSS*DWIDTH_DAT-1:0]   win_out,
    output logic                         win_valid,
    output logic [$clog2(IMG_H)-1:0]     win_row,
    output logic [$clog2(IMG_W)-1:0]     win_col,
    output logic                         frame_done
);

    localparam int DW = DWIDTH_DAT;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] EDGE_C   = CW'(N - 1);
    localparam logic [RW-1:0] EDGE_R   = RW'(N - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic          accept;
    logic          col_wrap;
    logic          last_pix;
    logic          fire;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;

    logic [DW-1:0] lb_wdata [N-1];
    logic [DW-1:0] lb_rdata [N-1];
    logic [DW-1:0] col_new  [N];
    logic [DW-1:0] taps     [N][N];
    logic [DW-1:0] taps_nxt [N][N];
    logic [DWSS*DW-1:0] win_pack;

    // sof relocates the accepted pixel to (0,0) in every state, abandoning any partial frame.
    always_comb begin
        accept   = pix_valid && (sof || state == ST_RUN);
        cur_col  = sof ? '0 : col;
        cur_row  = sof ? '0 : row;
        col_wrap = (cur_col == COL_LAST);
        last_pix = col_wrap && (cur_row == ROW_LAST);
        fire     = accept && (cur_row >= EDGE_R) && (cur_col >= EDGE_C);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (pix_valid && sof) begin
                    state_nxt = last_pix ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && last_pix) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (last_pix) begin
                col <= '0;
                row <= '0;
            end else if (col_wrap) begin
                col <= '0;
                row <= cur_row + RW'(1);
            end else begin
                col <= cur_col + CW'(1);
                row <= cur_row;
            end
        end
    end

    // Buffer 0 holds the previous row; each later buffer holds the row above its predecessor.
    for (genvar k = 0; k < N - 1; k++) begin : g_lb
        if (k == 0) begin : g_head
            assign lb_wdata[k] = pix_in;
        end else begin : g_tail
            assign lb_wdata[k] = lb_rdata[k-1];
        end

        conv_window_gen_line_buffer #(
            .DEPTH (IMG_W),
            .DW    (DW)
        ) u_line_buffer (
            .clk   (clk),
            .en    (accept),
            .addr  (cur_col),
            .wdata (lb_wdata[k]),
            .rdata (lb_rdata[k])
        );
    end

    always_comb begin
        col_new[N-1] = pix_in;
        for (int r = 0; r < N - 1; r++) begin
            col_new[r] = lb_rdata[N-2-r];
        end
    end

    always_comb begin
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N - 1; c++) begin
                taps_nxt[r][c] = taps[r][c+1];
            end
            taps_nxt[r][N-1] = col_new[r];
        end
    end

    always_comb begin
        win_pack = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                win_pack[DW*(r*N+c) +: DW] = taps_nxt[r][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            taps <= '{default: '0};
        end else if (accept) begin
            taps <= taps_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_out    <= '0;
            win_valid  <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= fire;
            frame_done <= accept && last_pix;
            if (fire) begin
                win_out <= win_pack;
                win_row <= cur_row - EDGE_R;
                win_col <= cur_col - EDGE_C;
            end
        end
    end

endmodule
